num_sender: RTL and testbench

Transmitter stage on the sending FPGA, directly upstream of the number receiver and calculator. On a `start` pulse it latches two operands and serialises them, little-endian byte by byte, over a single UART 8N1 line. The receiver samples that line as its `serial` input, which idles high. A one-cycle `done` pulse reports completion to local control logic.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/baud_tick.sv | 39 +++
 rtl/num_sender.sv | 155 +++++++++++++++
 tb/tb_num_sender.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions for the number sender and the number receiver.
//   Holds the sender FSM state encoding, the line levels of the start and
//   stop bits, and the default baud divider so both ends agree on one
//   bit period.
//   Contents:
//     uart_state_t          sender FSM states
//     START_BIT, STOP_BIT   line levels of the framing bits
//     DEFAULT_CLKS_PER_BIT  50 MHz / 9600 baud
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/baud_tick.sv
// baud_tick
//   Bit-period timer. While en is high it counts 0..CLKS_PER_BIT-1 and
//   emits a one-cycle tick on the last count, then wraps to 0. Dropping
//   en clears the count, so the first tick after enabling arrives exactly
//   CLKS_PER_BIT cycles later.
//   Ports:
//     clk   system clock
//     rst   asynchronous active-low reset
//     en    count enable
//     tick  one-cycle pulse at the end of each bit period
module baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!en || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/num_sender.sv
// num_sender
//   Sends two latched operands over a UART line, op_a then op_b, each
//   little-endian byte by byte, frames back-to-back. Each frame is a
//   start bit, 8 data bits LSB first, an optional even-parity bit and a
//   stop bit. All outputs are registered.
//   Build option: define NUM_SENDER_PARITY_EN to add the even-parity bit
//   (11-bit frames); without it frames are plain 8N1.
//   Ports:
//     clk     system clock
//     rst     asynchronous active-low reset
//     start   transfer request, ignored while busy
//     op_a    first operand, latched on an accepted start
//     op_b    second operand, latched on an accepted start
//     serial  UART line, idles high
//     busy    high while a transfer is in progress
//     done    one-cycle pulse in the first cycle after the last stop bit
//
//   state  | meaning
//   IDLE   | line high, waiting for start
//   START  | driving the start bit
//   DATA   | driving data bit bit_idx of the current byte
//   PARITY | driving the even-parity bit (parity builds only)
//   STOP   | driving the stop bit, then next byte or finish
module num_sender
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int OPW          = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [OPW-1:0] op_a,
   input  logic [OPW-1:0] op_b,
   output logic           serial,
   output logic           busy,
   output logic           done
);

   localparam int NB = 2 * OPW / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

   uart_state_t      state, state_nxt;
   logic [2:0]       bit_idx, bit_nxt;
   logic [BW-1:0]    byte_idx, byte_nxt;
   logic [2*OPW-1:0] shreg, shreg_nxt;
   logic             serial_nxt, busy_nxt, done_nxt;
   logic             tick;

   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (state != IDLE),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         serial   <= STOP_BIT;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_idx  <= bit_nxt;
         byte_idx <= byte_nxt;
         shreg    <= shreg_nxt;
         serial   <= serial_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_idx;
      byte_nxt  = byte_idx;
      shreg_nxt = shreg;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = START;
               shreg_nxt = {op_b, op_a};
               byte_nxt  = '0;
               bit_nxt   = '0;
            end
         end
         START: begin
            if (tick) begin
               state_nxt = DATA;
               bit_nxt   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_idx == 3'd7) begin
`ifdef NUM_SENDER_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  bit_nxt = bit_idx + 3'd1;
               end
            end
         end
`ifdef NUM_SENDER_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (byte_idx == LAST_BYTE) begin
                  state_nxt = IDLE;
                  byte_nxt  = '0;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = START;
                  byte_nxt  = byte_idx + 1'b1;
                  shreg_nxt = shreg >> 8;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Line level is derived from the next-cycle state and shift register so
   // the registered serial output changes on the same edge as the state.
   always_comb begin
      busy_nxt = (state_nxt != IDLE);
      case (state_nxt)
         START:   serial_nxt = START_BIT;
         DATA:    serial_nxt = shreg_nxt[bit_nxt];
`ifdef NUM_SENDER_PARITY_EN
         PARITY:  serial_nxt = ^shreg_nxt[7:0];
`endif
         default: serial_nxt = STOP_BIT;
      endcase
   end

endmodule

// File: tb/tb_num_sender.sv
// tb_num_sender
//   Bench for num_sender with CLKS_PER_BIT=4, OPW=16. The expected line
//   level for every cycle of a transfer is computed arithmetically from
//   the operand bytes and the frame layout. Honours NUM_SENDER_PARITY_EN.
module tb_num_sender;

   localparam int C   = 4;
   localparam int OPW = 16;
   localparam int NB  = 2 * OPW / 8;
`ifdef NUM_SENDER_PARITY_EN
   localparam int FB  = 11;
`else
   localparam int FB  = 10;
`endif
   localparam int XFER = NB * FB * C;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [OPW-1:0] op_a, op_b;
   logic           serial, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   num_sender #(
      .CLKS_PER_BIT(C),
      .OPW(OPW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .serial (serial),
      .busy   (busy),
      .done   (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Expected line level in cycle i (0 = first cycle after acceptance).
   function automatic logic exp_line(input logic [31:0] word, input int i);
      logic [7:0] bv;
      int k, p;
      k  = i / (FB * C);
      p  = (i % (FB * C)) / C;
      bv = 8'(word >> (8 * k));
      if (p == 0) return 1'b0;
      if (p <= 8) return bv[p-1];
      if (FB == 11 && p == 9) return ^bv;
      return 1'b1;
   endfunction

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_serial", serial, 1);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
      end
   endtask

   // One transfer: request at the next edge, then compare every cycle.
   // hold keeps start high throughout, inject_at re-pulses start with other
   // operands mid-transfer, abort_at drops reset mid-transfer.
   task automatic xfer(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                       input bit hold, input int inject_at, input int abort_at);
      logic [31:0] w;
      w     = {b, a};
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < XFER; i++) begin
         @(negedge clk);
         check("serial", serial, exp_line(w, i));
         check("busy", busy, 1);
         check("done_early", done, 0);
         if (i == inject_at) begin
            start = 1'b1;
            op_a  = ~a;
            op_b  = a ^ b ^ 16'h5555;
         end else if (!hold) begin
            start = 1'b0;
         end
         if (i == 1) begin
            op_a = OPW'($urandom);
            op_b = OPW'($urandom);
         end
         if (i == abort_at) begin
            #1 rst = 1'b0;
            #1;
            check("rst_serial", serial, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            start = 1'b0;
            return;
         end
      end
      @(negedge clk);
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_serial", serial, 1);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) @(negedge clk);
      check("reset_serial", serial, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst = 1'b1;
      idle_check(20);

      xfer(16'h1234, 16'h00FF, 1'b0, -1, -1);
      idle_check(5);

      xfer(16'hBEEF, 16'hC0DE, 1'b0, 39, -1);
      idle_check(10);

      xfer(16'h1357, 16'h2468, 1'b0, -1, 2 * FB * C + 3 * C + 1);
      repeat (3) begin
         @(negedge clk);
         check("inrst_serial", serial, 1);
         check("inrst_busy", busy, 0);
      end
      rst = 1'b1;
      idle_check(3);
      xfer(16'hCAFE, 16'h0102, 1'b0, -1, -1);
      idle_check(3);

      xfer(16'hA5A5, 16'h5A5A, 1'b1, -1, -1);
      xfer(16'hA5A5, 16'h5A5A, 1'b1, -1, -1);
      xfer(16'hA5A5, 16'h5A5A, 1'b0, -1, -1);
      idle_check(5);

      xfer(16'h0007, 16'h0000, 1'b0, -1, -1);
      idle_check(2);

      repeat (4) begin
         xfer(OPW'($urandom), OPW'($urandom), 1'b0, -1, -1);
         idle_check($urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
